// File: rtl/data_src_pkg.sv
// Shared types and default parameters for the data_src_sel write-data source multiplexer.
package data_src_pkg;

  localparam int unsigned DEF_N_IN    = 16;
  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_OVR_IDX = 8;
  localparam int unsigned DEF_OVR_VAL = 227;

  typedef enum logic {
    IDLE,
    SCAN
  } scan_state_t;

  typedef struct packed {
    logic                 en;
    logic [DEF_WIDTH-1:0] val;
  } ovr_entry_t;

endpackage

// File: rtl/data_src_ovr_table.sv
// Override register file: one {en, val} entry per channel, single write port,
// combinational read by index, reset preloads one entry.
module data_src_ovr_table
  import data_src_pkg::*;
#(
  parameter int unsigned N_IN        = DEF_N_IN,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned RST_OVR_IDX = DEF_OVR_IDX,
  parameter int unsigned RST_OVR_VAL = DEF_OVR_VAL,
  localparam int unsigned SW         = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [SW-1:0]    wr_idx,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_val,
  input  logic [SW-1:0]    rd_idx,
  output logic             rd_en,
  output logic [WIDTH-1:0] rd_val
);

  logic [N_IN-1:0]  en;
  logic [WIDTH-1:0] val [N_IN];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        en[i]  <= (i == RST_OVR_IDX);
        val[i] <= (i == RST_OVR_IDX) ? WIDTH'(RST_OVR_VAL) : '0;
      end
    end else if (we) begin
      en[wr_idx]  <= wr_en;
      val[wr_idx] <= wr_val;
    end
  end

  // Read sees the registered contents, so a same-cycle write is not yet visible.
  assign rd_en  = en[rd_idx];
  assign rd_val = val[rd_idx];

endmodule

// File: rtl/data_src_sel.sv
// Registered write-data source mux with override table and valid/ready output stage.
// Define DATA_SRC_SEL_SCAN_EN to build the debug scan engine that walks every channel.
module data_src_sel
  import data_src_pkg::*;
#(
  parameter int unsigned N_IN        = DEF_N_IN,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned RST_OVR_IDX = DEF_OVR_IDX,
  parameter int unsigned RST_OVR_VAL = DEF_OVR_VAL,
  localparam int unsigned SW         = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SW-1:0]         in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SW-1:0]         out_sel,
  output logic                  out_ovr,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  cfg_we,
  input  logic [SW-1:0]         cfg_idx,
  input  logic                  cfg_en,
  input  logic [WIDTH-1:0]      cfg_val,
  input  logic                  scan_start,
  output logic                  scan_busy
);

  logic             stage_free;
  logic             host_load;
  logic             scan_load;
  logic             load;
  logic             load_last;
  logic [SW-1:0]    load_sel;
  logic             ovr_hit;
  logic [WIDTH-1:0] ovr_val;
  logic [WIDTH-1:0] load_data;

  assign stage_free = !out_valid || out_ready;
  assign in_ready   = !scan_busy && stage_free;
  assign host_load  = in_valid && in_ready;
  assign load       = host_load || scan_load;

  data_src_ovr_table #(
    .N_IN        (N_IN),
    .WIDTH       (WIDTH),
    .RST_OVR_IDX (RST_OVR_IDX),
    .RST_OVR_VAL (RST_OVR_VAL)
  ) u_table (
    .clk    (clk),
    .reset  (reset),
    .we     (cfg_we),
    .wr_idx (cfg_idx),
    .wr_en  (cfg_en),
    .wr_val (cfg_val),
    .rd_idx (load_sel),
    .rd_en  (ovr_hit),
    .rd_val (ovr_val)
  );

  assign load_data = ovr_hit ? ovr_val : in_data[load_sel*WIDTH +: WIDTH];

`ifdef DATA_SRC_SEL_SCAN_EN
  scan_state_t   state;
  scan_state_t   state_nxt;
  logic [SW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && scan_start) begin
        cnt <= '0;
      end else if (scan_load) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scan_start) state_nxt = SCAN;
      SCAN:    if (scan_load && cnt == SW'(N_IN - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    scan_busy = (state == SCAN);
    scan_load = scan_busy && stage_free;
    load_last = scan_load && (cnt == SW'(N_IN - 1));
    load_sel  = scan_busy ? cnt : in_sel;
  end
`else
  logic unused_scan_start;

  assign unused_scan_start = scan_start;
  assign scan_busy         = 1'b0;
  assign scan_load         = 1'b0;
  assign load_last         = 1'b0;
  assign load_sel          = in_sel;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_ovr   <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_sel   <= load_sel;
      out_ovr   <= ovr_hit;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_src_sel.sv
// Testbench for data_src_sel: directed vector table, scan/reset sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_data_src_sel;

  localparam int unsigned N       = 16;
  localparam int unsigned W       = 32;
  localparam int unsigned SW      = 4;
  localparam int unsigned OVR_IDX = 8;
  localparam int unsigned OVR_VAL = 227;

`ifdef DATA_SRC_SEL_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N*W-1:0]  in_data;
  logic [SW-1:0]   in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ovr;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic            cfg_we;
  logic [SW-1:0]   cfg_idx;
  logic            cfg_en;
  logic [W-1:0]    cfg_val;
  logic            scan_start;
  logic            scan_busy;

  always #5 clk = ~clk;

  data_src_sel #(
    .N_IN        (N),
    .WIDTH       (W),
    .RST_OVR_IDX (OVR_IDX),
    .RST_OVR_VAL (OVR_VAL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_ovr    (out_ovr),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_en     (cfg_en),
    .cfg_val    (cfg_val),
    .scan_start (scan_start),
    .scan_busy  (scan_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: override table as arrays, output stage as a record, scan as a beat index.
  bit           m_en  [N];
  logic [W-1:0] m_val [N];
  bit           m_valid, m_ovr, m_last, m_busy;
  logic [W-1:0] m_data;
  int           m_sel, m_beat;

  logic          pre_rdy, cons, cons_last;
  logic [SW-1:0] cons_sel;
  logic [W-1:0]  cons_data;

  typedef struct {
    bit           rst_n, iv, ordy, we, wen;
    logic [SW-1:0] sel, widx;
    logic [W-1:0]  wval;
    bit           e_rdy, e_valid, e_ovr;
    logic [W-1:0]  e_data;
    logic [SW-1:0] e_sel;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i]  = (i == OVR_IDX);
      m_val[i] = (i == OVR_IDX) ? W'(OVR_VAL) : '0;
    end
    m_valid = 0; m_data = '0; m_sel = 0; m_ovr = 0; m_last = 0;
    m_busy = 0; m_beat = 0;
  endfunction

  function automatic void model_step();
    bit free, ld, lst;
    int k;
    if (!reset) begin
      model_reset();
      return;
    end
    free = !m_valid || out_ready;
    ld = 0; lst = 0; k = 0;
    if (m_busy) begin
      if (free) begin ld = 1; k = m_beat; lst = (m_beat == N - 1); end
    end else if (in_valid && free) begin
      ld = 1; k = int'(in_sel);
    end
    if (ld) begin
      m_valid = 1;
      m_ovr   = m_en[k];
      m_data  = m_en[k] ? m_val[k] : in_data[k*W +: W];
      m_sel   = k;
      m_last  = lst;
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (m_busy) begin
      if (ld) begin
        m_beat++;
        if (lst) m_busy = 0;
      end
    end else if (SCAN_EN && scan_start) begin
      m_busy = 1; m_beat = 0;
    end
    if (cfg_we) begin
      m_en[cfg_idx]  = cfg_en;
      m_val[cfg_idx] = cfg_val;
    end
  endfunction

  // One clock: check the combinational ready, take the edge, check every output.
  task automatic cycle();
    #1;
    pre_rdy   = in_ready;
    cons      = out_valid && out_ready;
    cons_sel  = out_sel;
    cons_last = out_last;
    cons_data = out_data;
    chk("in_ready", in_ready, !m_busy && (!m_valid || out_ready));
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_sel", out_sel, m_sel);
    chk("out_ovr", out_ovr, m_ovr);
    chk("out_last", out_last, m_last);
    chk("scan_busy", scan_busy, m_busy);
  endtask

  function automatic logic [W-1:0] pat(int k);
    return (k == 8) ? 32'h0000_DEAD : (32'hA000_0000 | W'(k));
  endfunction

  function automatic vec_t mk(bit r, bit iv, int sel, bit ordy, bit we, int widx, bit wen,
                              logic [W-1:0] wval, bit erdy, bit ev, logic [W-1:0] ed,
                              int es, bit eo);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.sel = SW'(sel); v.ordy = ordy; v.we = we;
    v.widx = SW'(widx); v.wen = wen; v.wval = wval; v.e_rdy = erdy;
    v.e_valid = ev; v.e_data = ed; v.e_sel = SW'(es); v.e_ovr = eo;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int beats, b0;
    bit found;

    reset = 0; in_valid = 0; in_sel = '0; out_ready = 1; cfg_we = 0; cfg_idx = '0;
    cfg_en = 0; cfg_val = '0; scan_start = 0;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = pat(k);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_ovr", out_ovr, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_scan_busy", scan_busy, 0);
    cycle();
    reset = 1;

    vecs[0]  = mk(1, 1, 8, 1, 0, 0, 0, 0, 1, 1, 227, 8, 1);
    vecs[1]  = mk(1, 1, 8, 1, 1, 8, 0, 0, 1, 1, 227, 8, 1);
    vecs[2]  = mk(1, 1, 8, 1, 0, 0, 0, 0, 1, 1, 32'hDEAD, 8, 0);
    for (int i = 0; i < 4; i++)
      vecs[3+i] = mk(1, 1, i, 1, 0, 0, 0, 0, 1, 1, pat(i), i, 0);
    for (int i = 7; i < 10; i++)
      vecs[i] = mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 1, pat(3), 3, 0);
    vecs[10] = mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, pat(3), 3, 0);
    vecs[11] = mk(1, 0, 0, 1, 1, 5, 1, 32'h1234, 1, 0, pat(3), 3, 0);
    vecs[12] = mk(1, 1, 5, 1, 0, 0, 0, 0, 1, 1, 32'h1234, 5, 1);
    vecs[13] = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[14] = mk(1, 1, 5, 1, 0, 0, 0, 0, 1, 1, pat(5), 5, 0);
    vecs[15] = mk(1, 1, 8, 1, 0, 0, 0, 0, 1, 1, 227, 8, 1);
    vecs[16] = mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 227, 8, 1);

    foreach (vecs[i]) begin
      reset = vecs[i].rst_n; in_valid = vecs[i].iv; in_sel = vecs[i].sel;
      out_ready = vecs[i].ordy; cfg_we = vecs[i].we; cfg_idx = vecs[i].widx;
      cfg_en = vecs[i].wen; cfg_val = vecs[i].wval;
      cycle();
      chk($sformatf("v%0d_in_ready", i), pre_rdy, vecs[i].e_rdy);
      chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_data", i), out_data, vecs[i].e_data);
      chk($sformatf("v%0d_sel", i), out_sel, vecs[i].e_sel);
      chk($sformatf("v%0d_ovr", i), out_ovr, vecs[i].e_ovr);
    end
    reset = 1; cfg_we = 0; in_valid = 0; out_ready = 1;

    if (SCAN_EN) begin
      // Full scan with a stalling consumer and a host request parked behind it.
      scan_start = 1;
      cycle();
      scan_start = 0;
      chk("scan_busy_rise", scan_busy, 1);
      in_valid = 1; in_sel = 4'd2;
      beats = 0;
      for (int c = 0; c < 100 && beats < 17; c++) begin
        out_ready = (c % 2 == 0);
        b0 = beats;
        cycle();
        if (b0 < 15) chk("scan_in_ready_low", pre_rdy, 0);
        if (cons) begin
          if (beats < 16) begin
            chk($sformatf("scan_sel_%0d", beats), cons_sel, beats);
            chk($sformatf("scan_last_%0d", beats), cons_last, beats == 15);
            chk($sformatf("scan_data_%0d", beats), cons_data, (beats == 8) ? W'(227) : pat(beats));
          end else begin
            chk("host_after_scan_sel", cons_sel, 2);
            chk("host_after_scan_last", cons_last, 0);
            chk("host_after_scan_data", cons_data, pat(2));
          end
          beats++;
        end
      end
      chk("scan_beat_count", beats, 17);
      in_valid = 0; out_ready = 1;
      cycle();
      cycle();

      // Reset in the middle of a scan, then a fresh scan restarts at channel 0.
      scan_start = 1;
      cycle();
      scan_start = 0;
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
        cycle();
        if (out_valid && out_sel == 4'd6) found = 1;
      end
      chk("scan_reached_beat6", found, 1);
      reset = 0;
      cycle();
      reset = 1;
      chk("midscan_rst_valid", out_valid, 0);
      chk("midscan_rst_data", out_data, 0);
      chk("midscan_rst_sel", out_sel, 0);
      chk("midscan_rst_last", out_last, 0);
      chk("midscan_rst_busy", scan_busy, 0);
      cycle();
      chk("midscan_no_resume", out_valid, 0);
      scan_start = 1;
      cycle();
      scan_start = 0;
      cycle();
      chk("rescan_first_valid", out_valid, 1);
      chk("rescan_first_sel", out_sel, 0);
      for (int c = 0; c < 40 && scan_busy; c++) cycle();
      chk("rescan_done", scan_busy, 0);
    end else begin
      scan_start = 1;
      cycle();
      scan_start = 0;
      chk("noscan_busy", scan_busy, 0);
      cycle();
      chk("noscan_last", out_last, 0);
    end

    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 99) != 0);
      in_valid   = 1'($urandom_range(0, 1));
      in_sel     = SW'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 9) == 0);
      cfg_idx    = SW'($urandom);
      cfg_en     = 1'($urandom);
      cfg_val    = $urandom;
      scan_start = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
